// File: rtl/mul_div_pkg.sv
// Shared opcode/state encodings and the sign/magnitude helper for the
// iterative multiply/divide unit.
package mul_div_pkg;

    // Widest operand the helper function handles.
    localparam int MAX_W = 64;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        MD_DIV   = 2'b00,
        MD_DIVU  = 2'b01,
        MD_MULT  = 2'b10,
        MD_MULTU = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

    // mag sits above neg so a caller can size-cast the result to {mag[w-1:0], neg}.
    typedef struct packed {
        logic [MAX_W-1:0] mag;
        logic             neg;
    } abs_t;

    function automatic abs_t abs_sign(input logic [MAX_W-1:0] v,
                                      input int               w,
                                      input logic             is_signed);
        abs_t r;
        r.neg = is_signed && v[IDX_W'(w - 1)];
        r.mag = r.neg ? (~v + MAX_W'(1)) : v;
        return r;
    endfunction

endpackage

// File: rtl/mul_div_core.sv
// Unsigned radix-2 datapath: shift-add multiply over {rem, acc} or restoring
// divide with acc collecting quotient bits, one step per cycle.
module mul_div_core #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             skip_i,
    input  logic             run_i,
    input  logic             flush_i,
    input  logic             is_mul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q;
    logic             mul_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;

    always_comb begin
        mul_sum = {1'b0, rem_q} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // WIDTH+1-bit partial remainder; its top bit is the borrow of the trial subtract.
        trial   = {rem_q, acc_q[WIDTH-1]} - {1'b0, opnd_q};
        if (mul_q) begin
            rem_d = mul_sum[WIDTH:1];
            acc_d = {mul_sum[0], acc_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            acc_d = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], acc_q[WIDTH-1]};
            acc_d = {acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            mul_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q  <= '0;
            acc_q  <= a_i;
            opnd_q <= b_i;
            mul_q  <= is_mul_i;
            cnt_q  <= skip_i ? '0 : CNT_W'(WIDTH);
        end else if (run_i && (cnt_q != '0)) begin
            rem_q <= rem_d;
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign hi_o   = rem_q;
    assign lo_o   = acc_q;
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle div/divu/mult/multu unit: FSM, sign handling, divide-by-zero
// and cancel around the unsigned iterative core; HI/LO are registered here.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mdOp,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] doutHi,
    output logic [WIDTH-1:0] doutLo
);

    state_t             state_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q, din1_q;
    logic               is_mul_q, dz_q, neg_res_q, neg_rem_q;

    md_op_t             op;
    logic               op_signed, op_mul, div_zero, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   core_hi, core_lo;
    logic               core_last;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        op             = md_op_t'(mdOp);
        op_signed      = (op == MD_DIV) || (op == MD_MULT);
        op_mul         = (op == MD_MULT) || (op == MD_MULTU);
        div_zero       = !op_mul && (din2 == '0);
        {a_mag, a_neg} = (WIDTH + 1)'(abs_sign(MAX_W'(din1), WIDTH, op_signed));
        {b_mag, b_neg} = (WIDTH + 1)'(abs_sign(MAX_W'(din2), WIDTH, op_signed));
    end

    assign accept = (state_q == ST_IDLE) && start;

    mul_div_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .skip_i   (div_zero),
        .run_i    ((state_q == ST_CALC) && !cancel),
        .flush_i  (cancel && (state_q != ST_IDLE)),
        .is_mul_i (op_mul),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .hi_o     (core_hi),
        .lo_o     (core_lo),
        .last_o   (core_last)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        prod   = neg_res_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        res_hi = core_hi;
        res_lo = core_lo;
        if (dz_q) begin
            res_hi = din1_q;
            res_lo = '1;
        end else if (is_mul_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else begin
            if (neg_res_q) res_lo = -core_lo;
            if (neg_rem_q) res_hi = -core_hi;
        end
    end

    // NOTE: reset is synchronous and tested first, so it overrides start and cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            din1_q    <= '0;
            is_mul_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        din1_q    <= din1;
                        is_mul_q  <= op_mul;
                        dz_q      <= div_zero;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        busy_q    <= 1'b1;
                        state_q   <= div_zero ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (core_last) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign doutHi = hi_q;
    assign doutLo = lo_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq: arithmetic reference model plus per-cycle
// scoreboard for the 32-bit unit, and a short latency/result sweep at WIDTH=8.
module tb_mul_div_seq;
    import mul_div_pkg::*;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, cancel = 1'b0;
    logic [1:0]    md_op = 2'b00;
    logic [W-1:0]  din1 = '0, din2 = '0;
    logic          busy, done;
    logic [W-1:0]  dout_hi, dout_lo;

    logic          start8 = 1'b0, cancel8 = 1'b0;
    logic [1:0]    md_op8 = 2'b00;
    logic [W8-1:0] din1_8 = '0, din2_8 = '0;
    logic          busy8, done8;
    logic [W8-1:0] dout_hi8, dout_lo8;

    always #5 clk = ~clk;

    mul_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mdOp(md_op), .din1(din1), .din2(din2),
        .cancel(cancel), .busy(busy), .done(done), .doutHi(dout_hi), .doutLo(dout_lo)
    );

    mul_div_seq #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mdOp(md_op8), .din1(din1_8), .din2(din2_8),
        .cancel(cancel8), .busy(busy8), .done(done8), .doutHi(dout_hi8), .doutLo(dout_lo8)
    );

    typedef struct {
        int          iss;
        int          due;
        logic [63:0] hi;
        logic [63:0] lo;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    logic        rst_at_edge = 1'b1;
    logic [63:0] exp_hi = '0, exp_lo = '0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic at operand width w (w <= 32).
    function automatic logic [127:0] model(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] mask, hi, lo;
        longint      sa, sb, p;
        mask = (64'd1 << w) - 64'd1;
        sa   = $signed(a << (64 - w)) >>> (64 - w);
        sb   = $signed(b << (64 - w)) >>> (64 - w);
        p    = (op == MD_MULT) ? sa * sb : longint'(a * b);
        if (op[1]) begin
            hi = (64'(p) >> w) & mask;
            lo = 64'(p) & mask;
        end else if (b == 64'd0) begin
            hi = a;
            lo = mask;
        end else if (op == MD_DIV) begin
            hi = 64'(sa % sb) & mask;
            lo = 64'(sa / sb) & mask;
        end else begin
            hi = (a % b) & mask;
            lo = (a / b) & mask;
        end
        return {hi, lo};
    endfunction

    task automatic pin(input string name, input logic [127:0] got,
                       input logic [63:0] hi, input logic [63:0] lo);
        check({name, " hi"}, got[127:64], hi);
        check({name, " lo"}, got[63:0], lo);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit in_flight(input int c);
        bit f = 1'b0;
        foreach (q[i]) if (c >= q[i].iss + 1 && c <= q[i].due - 1) f = 1'b1;
        return f;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic with_cancel = 1'b0);
        logic [127:0] m;
        if (!in_flight(cyc)) begin
            m = model(op, 64'(a), 64'(b), W);
            q.push_back('{iss: cyc, due: cyc + ((!op[1] && b == '0) ? 2 : W + 2),
                          hi: m[127:64], lo: m[63:0]});
        end
        md_op  = op;
        din1   = a;
        din2   = b;
        start  = 1'b1;
        cancel = with_cancel;
        tick(1);
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic abort();
        int k;
        k      = cyc;
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (k >= q[i].iss + 1 && k <= q[i].due - 1) q.delete(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    // Scoreboard: busy/done timing and held HI/LO, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            bit e_busy, e_done;
            if (rst_at_edge) begin
                q.delete();
                exp_hi = '0;
                exp_lo = '0;
            end
            e_busy = in_flight(cyc);
            e_done = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e_done = 1'b1;
                exp_hi = q[0].hi;
                exp_lo = q[0].lo;
                q.delete(0);
            end
            check("busy",   64'(busy),    64'(e_busy));
            check("done",   64'(done),    64'(e_done));
            check("doutHi", 64'(dout_hi), exp_hi);
            check("doutLo", 64'(dout_lo), exp_lo);
        end
    end

    task automatic run8(input logic [1:0] op, input logic [W8-1:0] a, input logic [W8-1:0] b);
        logic [127:0] m;
        int           lat;
        m      = model(op, 64'(a), 64'(b), W8);
        lat    = (!op[1] && b == '0) ? 2 : W8 + 2;
        md_op8 = op;
        din1_8 = a;
        din2_8 = b;
        start8 = 1'b1;
        tick(1);
        start8 = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            check("w8 busy", 64'(busy8), 64'(n < lat));
            check("w8 done", 64'(done8), 64'(n == lat));
            if (n == lat) begin
                check("w8 doutHi", 64'(dout_hi8), m[127:64]);
                check("w8 doutLo", 64'(dout_lo8), m[63:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        pin("model div 5/-3",    model(MD_DIV,   64'h5,         64'hFFFF_FFFD, W), 64'h2,         64'hFFFF_FFFF);
        pin("model multu",       model(MD_MULTU, 64'hABCD_CDEF, 64'h1234_5678, W), 64'h0C37_9850, 64'h4E32_D208);
        pin("model mult -5*3",   model(MD_MULT,  64'hFFFF_FFFB, 64'h3,         W), 64'hFFFF_FFFF, 64'hFFFF_FFF1);
        pin("model divu 7/0",    model(MD_DIVU,  64'h7,         64'h0,         W), 64'h7,         64'hFFFF_FFFF);
        pin("model div min/-1",  model(MD_DIV,   64'h8000_0000, 64'hFFFF_FFFF, W), 64'h0,         64'h8000_0000);
        pin("model div -7/2",    model(MD_DIV,   64'hFFFF_FFF9, 64'h2,         W), 64'hFFFF_FFFF, 64'hFFFF_FFFD);
        pin("model divu 100/7",  model(MD_DIVU,  64'd100,       64'd7,         W), 64'd2,         64'd14);
        pin("model w8 mult",     model(MD_MULT,  64'hFB,        64'h03,        W8), 64'hFF,       64'hF1);

        tick(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick(3);

        issue(MD_DIV,   32'd5,          32'hFFFF_FFFD); tick(W + 3);
        issue(MD_MULTU, 32'hABCD_CDEF,  32'h1234_5678); tick(W + 3);
        issue(MD_MULT,  32'hFFFF_FFFB,  32'd3);         tick(W + 3);
        issue(MD_DIVU,  32'd7,          32'd0);         tick(4);
        issue(MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF); tick(W + 3);
        issue(MD_DIV,   32'hFFFF_FFF9,  32'd2);         tick(W + 3);

        // Cancel mid-CALC, cancel while idle, then start+cancel together while idle.
        issue(MD_DIVU, 32'd100, 32'd7); tick(9); abort(); tick(5);
        abort(); tick(2);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1); tick(W + 3);

        // A start during busy is dropped; a start on the done cycle is taken.
        issue(MD_MULTU, 32'h0001_0003, 32'h0002_0005);
        tick(5);
        issue(MD_DIV, 32'd1, 32'd1);
        tick(W + 2 - 7);
        issue(MD_MULT, 32'hFFFF_FFFB, 32'd3);
        tick(W + 3);
        issue(MD_DIVU, 32'd9, 32'd0); tick(4);

        // Reset in the middle of CALC.
        issue(MD_MULTU, 32'hDEAD_BEEF, 32'h0000_1234); tick(10);
        do_reset(); tick(3);

        run8(MD_MULT,  8'hFB, 8'h03);
        run8(MD_MULTU, 8'hFB, 8'h03);
        run8(MD_DIV,   8'h80, 8'hFF);
        run8(MD_DIV,   8'hF9, 8'h02);
        run8(MD_DIVU,  8'h07, 8'h00);
        run8(MD_DIVU,  8'd200, 8'd7);
        tick(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
Parametrised multi-cycle multiply/divide unit, successor to the single-cycle combinational MulDiv. Executes div, divu, mult and multu with a radix-2 iterative datapath, so the EX stage no longer carries a full-width combinational multiplier/divider. The pipeline issues an op with a start pulse, stalls on busy, and the HI/LO result registers are written on done. Adds divide-by-zero and overflow handling, plus cancel for exception flush.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits (minimum 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; accepted only when busy=0
mdOp  input  2  00 div, 01 divu, 10 mult, 11 multu; sampled with start
din1  input  WIDTH  dividend / multiplicand; sampled with start
din2  input  WIDTH  divisor / multiplier; sampled with start
cancel  input  1  abort the in-flight op (pipeline flush)
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse; doutHi/doutLo are valid in that cycle
doutHi  output  WIDTH  mult: high product half; div: remainder
doutLo  output  WIDTH  mult: low product half; div: quotient

Behaviour:
- Reset: state IDLE, busy=0, done=0, doutHi=0, doutLo=0, counter=0. Reset overrides start and cancel in the same cycle.
- States: IDLE -> CALC -> FIX -> IDLE. done is asserted in the cycle after FIX, with state already IDLE.
- IDLE, start=1: latch the operands, compute magnitudes (abs for signed ops, unchanged for unsigned), record the result signs, load counter=WIDTH, go to CALC.
- CALC: one iteration per cycle; counter decrements; leave for FIX when counter reaches 0. This takes exactly WIDTH cycles.
  - mult: shift-add over a 2*WIDTH accumulator.
  - div: restoring division with a WIDTH+1-bit partial remainder.
- FIX:
  - mult: negate the 2*WIDTH product if the operand signs differ.
  - div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Register the results into doutHi/doutLo.
- Latency: start sampled at edge N -> done=1 during cycle N+WIDTH+2 (34 cycles for WIDTH=32). busy=1 from cycle N+1 through N+WIDTH+1, and is 0 when done=1.
- Divide by zero (din2==0, div/divu): skip CALC and go straight to FIX. Result doutHi=din1, doutLo=all ones. done arrives 2 cycles after start.
- Signed overflow (div, din1=MIN, din2=-1): natural result doutLo=MIN, doutHi=0. No trap; this falls out of the magnitude datapath.
- mult/multu have no overflow condition; the full 2*WIDTH product is always produced.
- start while busy=1: ignored, no effect on the in-flight op. start in the same cycle that done=1 is accepted (back-to-back issue).
- cancel in CALC or FIX: next state IDLE, busy=0, no done. doutHi/doutLo keep the previous result. cancel in IDLE is a no-op.
- start and cancel together while IDLE: start wins.
- doutHi/doutLo change only on the FIX->IDLE transition or on reset. They are held between ops.

Decomposition:
- mul_div_pkg holds:
  - the mdOp encodings (MD_DIV=2'b00, MD_DIVU=2'b01, MD_MULT=2'b10, MD_MULTU=2'b11);
  - the state enum (ST_IDLE, ST_CALC, ST_FIX);
  - a helper function returning abs value and sign.
- One sub-module, mul_div_core: the unsigned iterative shift-add / restoring-divide datapath with its counter. The top level owns the FSM, sign handling, special cases and output registers.

Test Plan:
- div: din1=5, din2=-3 -> doutHi=32'h0000_0002, doutLo=32'hFFFF_FFFF. done exactly 34 cycles after start; busy high for 33 cycles.
- multu: 32'hABCD_CDEF * 32'h1234_5678 -> doutHi=32'h0C37_9850, doutLo=32'h4E32_D208. mult: -5 * 3 -> doutHi=32'hFFFF_FFFF, doutLo=32'hFFFF_FFF1.
- Special cases:
  - divu 7/0 -> doutHi=7, doutLo=32'hFFFF_FFFF, done 2 cycles after start.
  - div 32'h8000_0000 / -1 -> doutLo=32'h8000_0000, doutHi=0.
  - div -7/2 -> doutLo=-3, doutHi=-1.
- Cancel: start divu 100/7, assert cancel at cycle 10 -> busy=0 next cycle, no done, outputs keep the prior values. Then a fresh start of divu 100/7 completes with doutLo=14, doutHi=2.
- Handshake: a second start during busy is ignored (the result matches the first op). A start on the done cycle is accepted, and its done arrives 34 cycles later.
- Reset and width: rst asserted mid-CALC -> next cycle busy=0, done=0, doutHi=doutLo=0. Re-run the multu and div cases with WIDTH=8 (e.g. mult -5*3 -> 8'hFF/8'hF1, latency 10).
